// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Op codes, FSM state encoding and the code-range boundaries for mul/div.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OpAdd    = 5'h00,
    OpSub    = 5'h01,
    OpAnd    = 5'h02,
    OpOr     = 5'h03,
    OpXor    = 5'h04,
    OpSlt    = 5'h05,
    OpSltu   = 5'h06,
    OpSll    = 5'h07,
    OpSra    = 5'h08,
    OpSrl    = 5'h09,
    OpMul    = 5'h0A,
    OpMulh   = 5'h0B,
    OpMulhsu = 5'h0C,
    OpMulhu  = 5'h0D,
    OpDiv    = 5'h0E,
    OpDivu   = 5'h0F,
    OpRem    = 5'h10,
    OpRemu   = 5'h11
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } seq_alu_state_e;

  localparam logic [4:0] MulFirst = 5'h0A;
  localparam logic [4:0] DivFirst = 5'h0E;
  localparam logic [4:0] DivLast  = 5'h11;

endpackage

// File: rtl/seq_muldiv_iter.sv
// Iterative multiply / divide datapath.
// Multiply: XLEN shift-add steps on a 2*XLEN product; a signed multiplier's MSB step subtracts.
// Divide: XLEN restoring steps on operand magnitudes, sign-corrected on the final step.
// o_done/o_result are combinational during the last step so the caller can register them.
module seq_muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PW  = 2 * XLEN;

  logic [SHW-1:0]  r_cnt;
  logic            r_busy, r_is_div, r_b_signed, r_hi, r_neg_q, r_neg_r, r_want_rem;
  logic [PW-1:0]   r_prod, r_mcand;
  logic [XLEN-1:0] r_mplier, r_rem, r_quo, r_divisor;

  logic            w_a_signed, w_div_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_last;
  logic [PW-1:0]   w_addend, w_prod_nxt;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;

  // Operand preparation at start: sign handling per op.
  always_comb begin
    w_a_signed   = (i_op == OpMulh) || (i_op == OpMulhsu);
    w_div_signed = (i_op == OpDiv) || (i_op == OpRem);
    w_a_neg      = w_div_signed && i_a[XLEN-1];
    w_b_neg      = w_div_signed && i_b[XLEN-1];
    w_a_mag      = w_a_neg ? -i_a : i_a;
    w_b_mag      = w_b_neg ? -i_b : i_b;
  end

  // One iteration step for both datapaths, plus the sign-corrected final result.
  always_comb begin
    w_last     = (r_cnt == SHW'(XLEN - 1));
    // Signed multiplier: the MSB carries weight -2^(XLEN-1).
    w_addend   = (r_b_signed && w_last) ? -r_mcand : r_mcand;
    w_prod_nxt = r_mplier[0] ? (r_prod + w_addend) : r_prod;
    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_divisor};
    if (w_diff[XLEN]) begin
      w_rem_nxt = w_shift[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
    end else begin
      w_rem_nxt = w_diff[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
    end
    w_q_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    w_r_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    if (r_is_div) begin
      o_result = r_want_rem ? w_r_fix : w_q_fix;
    end else begin
      o_result = r_hi ? w_prod_nxt[PW-1:XLEN] : w_prod_nxt[XLEN-1:0];
    end
    o_done = r_busy && w_last;
  end

  // Load operands on start, then step once per cycle until the last iteration.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_b_signed <= 1'b0;
      r_hi       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_want_rem <= 1'b0;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= '0;
      r_is_div   <= i_op inside {OpDiv, OpDivu, OpRem, OpRemu};
      r_b_signed <= (i_op == OpMulh);
      r_hi       <= (i_op != OpMul);
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_want_rem <= (i_op == OpRem) || (i_op == OpRemu);
      r_prod     <= '0;
      r_mcand    <= w_a_signed ? {{XLEN{i_a[XLEN-1]}}, i_a} : {{XLEN{1'b0}}, i_a};
      r_mplier   <= i_b;
      r_rem      <= '0;
      r_quo      <= w_a_mag;
      r_divisor  <= w_b_mag;
    end else if (r_busy) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Base ops, undefined codes and divide special cases retire one cycle after accept;
// mul*/div/rem iterate for XLEN cycles in seq_muldiv_iter.
// Build option: SEQ_ALU_FAST_MUL_EN selects a combinational multiplier (1-cycle mul*).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  seq_alu_state_e  r_state;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid, r_zero, r_eq, r_lt, r_ltu;

  alu_op_e         w_op;
  logic            w_is_mul, w_is_div, w_div_signed, w_div_by_zero, w_div_ovf;
  logic            w_iter_mul, w_iter_div, w_accept, w_md_start, w_md_done;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_quick, w_md_result;
`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
`endif

  assign w_op = alu_op_e'(op);

  // Op classification, single-cycle results and divide special cases.
  always_comb begin
    w_is_mul      = (op >= MulFirst) && (op < DivFirst);
    w_is_div      = (op >= DivFirst) && (op <= DivLast);
    w_div_signed  = (w_op == OpDiv) || (w_op == OpRem);
    w_div_by_zero = (b == '0);
    w_div_ovf     = w_div_signed && (a == MinNeg) && (b == '1);
`ifdef SEQ_ALU_FAST_MUL_EN
    w_iter_mul = 1'b0;
    w_a_ext    = ((w_op == OpMulh) || (w_op == OpMulhsu)) ? {{XLEN{a[XLEN-1]}}, a}
                                                          : {{XLEN{1'b0}}, a};
    w_b_ext    = (w_op == OpMulh) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    w_prod     = w_a_ext * w_b_ext;
`else
    w_iter_mul = w_is_mul;
`endif
    w_iter_div = w_is_div && !w_div_by_zero && !w_div_ovf;
    w_accept   = in_valid && (r_state == StIdle);
    w_md_start = w_accept && (w_iter_mul || w_iter_div);
    w_shamt    = b[SHW-1:0];
    w_quick    = '0;
    case (w_op)
      OpAdd:  w_quick = a + b;
      OpSub:  w_quick = a - b;
      OpAnd:  w_quick = a & b;
      OpOr:   w_quick = a | b;
      OpXor:  w_quick = a ^ b;
      OpSlt:  w_quick = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: w_quick = {{(XLEN-1){1'b0}}, a < b};
      OpSll:  w_quick = a << w_shamt;
      OpSra:  w_quick = $unsigned($signed(a) >>> w_shamt);
      OpSrl:  w_quick = a >> w_shamt;
`ifdef SEQ_ALU_FAST_MUL_EN
      OpMul:                     w_quick = w_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_quick = w_prod[2*XLEN-1:XLEN];
`endif
      // Only reached for the special cases; regular divides iterate.
      OpDiv, OpDivu: w_quick = w_div_by_zero ? '1 : a;
      OpRem, OpRemu: w_quick = w_div_by_zero ? a : '0;
      default:       w_quick = '0;
    endcase
  end

  seq_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_start (w_md_start),
    .i_op    (w_op),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_result(w_md_result)
  );

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_eq  <= (a == b);
            r_lt  <= ($signed(a) < $signed(b));
            r_ltu <= (a < b);
            if (w_iter_mul) begin
              r_state <= StMul;
            end else if (w_iter_div) begin
              r_state <= StDiv;
            end else begin
              r_state     <= StDone;
              r_result    <= w_quick;
              r_zero      <= (w_quick == '0);
              r_out_valid <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          if (w_md_done) begin
            r_state     <= StDone;
            r_result    <= w_md_result;
            r_zero      <= (w_md_result == '0);
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign eq        = r_eq;
  assign lt        = r_lt;
  assign ltu       = r_ltu;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32): scoreboard of expected results/flags/latency.
module tb_seq_alu;

  localparam int XLEN = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = XLEN + 1;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;  // {zero, eq, lt, ltu}
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, eq, lt, ltu;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  seq_alu #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .eq       (eq),
    .lt       (lt),
    .ltu      (ltu)
  );

  function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] sx, sy, ux, uy, p;
    logic signed [31:0] xs, ys;
    logic ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    xs  = x;
    ys  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    e.lat = 1;
    e.res = '0;
    p = '0;
    case (o)
      5'h00: e.res = x + y;
      5'h01: e.res = x - y;
      5'h02: e.res = x & y;
      5'h03: e.res = x | y;
      5'h04: e.res = x ^ y;
      5'h05: e.res = (xs < ys) ? 32'd1 : 32'd0;
      5'h06: e.res = (x < y) ? 32'd1 : 32'd0;
      5'h07: e.res = x << y[4:0];
      5'h08: e.res = xs >>> y[4:0];
      5'h09: e.res = x >> y[4:0];
      5'h0A: begin p = ux * uy; e.res = p[31:0];  e.lat = MulLat; end
      5'h0B: begin p = sx * sy; e.res = p[63:32]; e.lat = MulLat; end
      5'h0C: begin p = sx * uy; e.res = p[63:32]; e.lat = MulLat; end
      5'h0D: begin p = ux * uy; e.res = p[63:32]; e.lat = MulLat; end
      5'h0E: begin
        if (y == 0) e.res = '1;
        else if (ovf) e.res = x;
        else begin e.res = xs / ys; e.lat = XLEN + 1; end
      end
      5'h0F: begin
        if (y == 0) e.res = '1;
        else begin e.res = x / y; e.lat = XLEN + 1; end
      end
      5'h10: begin
        if (y == 0) e.res = x;
        else if (ovf) e.res = '0;
        else begin e.res = xs % ys; e.lat = XLEN + 1; end
      end
      5'h11: begin
        if (y == 0) e.res = x;
        else begin e.res = x % y; e.lat = XLEN + 1; end
      end
      default: e.res = '0;
    endcase
    e.flg = {e.res == 32'd0, x == y, xs < ys, x < y};
    return e;
  endfunction

  // Present one op, wait for acceptance and then for out_valid; lat = -1 on timeout.
  task automatic drive_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_hs got v/r=%b want 01", {out_valid, in_ready});
    end
    n_cmp++;
    if (result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result got %h want 0", result);
    end
    n_cmp++;
    if ({zero, eq, lt, ltu} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {zero, eq, lt, ltu});
    end
  endtask

  task automatic run_table(input string name, input logic [4:0] ops[], input logic [31:0] xs[],
                           input logic [31:0] ys[]);
    exp_t e;
    int lat;
    for (int i = 0; i < ops.size(); i++) begin
      sb_q.push_back(model(ops[i], xs[i], ys[i]));
      drive_op(ops[i], xs[i], ys[i], lat);
      e = sb_q.pop_front();
      n_cmp++;
      if (result !== e.res) begin
        n_fail++; $display("FAIL %s[%0d] result got %h want %h", name, i, result, e.res);
      end
      n_cmp++;
      if ({zero, eq, lt, ltu} !== e.flg) begin
        n_fail++; $display("FAIL %s[%0d] flags got %b want %b", name, i, {zero, eq, lt, ltu}, e.flg);
      end
      n_cmp++;
      if (lat !== e.lat) begin
        n_fail++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, e.lat);
      end
      retire();
    end
  endtask

  task automatic test_base();
    logic [4:0]  ops[] = '{5'h00, 5'h01, 5'h04, 5'h07, 5'h08, 5'h09, 5'h05, 5'h06, 5'h15};
    logic [31:0] xs[]  = '{32'd5, 32'd9, 32'hF0F0_1234, 32'h0000_0003, 32'h8000_0010,
                           32'h8000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd77};
    logic [31:0] ys[]  = '{32'd7, 32'd9, 32'h0FF0_FFFF, 32'd33, 32'd4, 32'd36, 32'd1, 32'd1,
                           32'd3};
    run_table("base", ops, xs, ys);
  endtask

  task automatic test_mul();
    logic [4:0]  ops[] = '{5'h0A, 5'h0D, 5'h0B, 5'h0C, 5'h0B, 5'h0A};
    logic [31:0] xs[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'h8000_0000, 32'd12345};
    logic [31:0] ys[]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'h8000_0000, 32'd6789};
    run_table("mul", ops, xs, ys);
  endtask

  task automatic test_div();
    logic [4:0]  ops[] = '{5'h0E, 5'h10, 5'h0F, 5'h11, 5'h0E, 5'h10, 5'h0E};
    logic [31:0] xs[]  = '{-32'sd7, -32'sd7, 32'd100, 32'd100, 32'd7, -32'sd7, 32'h8000_0000};
    logic [31:0] ys[]  = '{32'd2, 32'd2, 32'd7, 32'd7, -32'sd2, -32'sd2, 32'd3};
    run_table("div", ops, xs, ys);
  endtask

  task automatic test_div_special();
    logic [4:0]  ops[] = '{5'h0F, 5'h11, 5'h0E, 5'h10, 5'h0E, 5'h10};
    logic [31:0] xs[]  = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd5, -32'sd5};
    logic [31:0] ys[]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    run_table("divspec", ops, xs, ys);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    sb_q.push_back(model(5'h0F, 32'd100, 32'd7));
    drive_op(5'h0F, 32'd100, 32'd7, lat);
    e = sb_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat);
    end
    for (int i = 0; i < 5; i++) begin
      op = 5'h00; a = 32'd1; b = 32'd1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      n_cmp++;
      if (result !== e.res || {zero, eq, lt, ltu} !== e.flg) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %h/%b want %h/%b", i, result,
                           {zero, eq, lt, ltu}, e.res, e.flg);
      end
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10) begin
        n_fail++; $display("FAIL bp_hs[%0d] got v/r=%b want 10", i, {out_valid, in_ready});
      end
    end
    in_valid = 1'b0;
    retire();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release got v/r=%b want 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_no_extra got v/r=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int lat;
    op = 5'h0E; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01 || result !== 32'd0) begin
      n_fail++; $display("FAIL abort_state got v/r=%b res=%h want 01 res=0",
                         {out_valid, in_ready}, result);
    end
    repeat (XLEN + 2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_output got out_valid=%b want 0", out_valid);
    end
    sb_q.push_back(model(5'h00, 32'd1, 32'd1));
    drive_op(5'h00, 32'd1, 32'd1, lat);
    e = sb_q.pop_front();
    n_cmp++;
    if (result !== e.res || lat !== e.lat) begin
      n_fail++; $display("FAIL abort_then_add got %h lat %0d want %h lat %0d", result, lat,
                         e.res, e.lat);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    logic [4:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 5'($urandom_range(0, 31));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      sb_q.push_back(model(o, x, y));
      drive_op(o, x, y, lat);
      e = sb_q.pop_front();
      n_cmp++;
      if (result !== e.res || {zero, eq, lt, ltu} !== e.flg || lat !== e.lat) begin
        n_fail++; $display("FAIL b2b[%0d] op=%h a=%h b=%h got %h/%b/%0d want %h/%b/%0d", i, o, x,
                           y, result, {zero, eq, lt, ltu}, lat, e.res, e.flg, e.lat);
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
